health_bar: RTL



---
 rtl/health_bar_pkg.sv | 27 ++
 rtl/health_bar_if.sv | 13 +
 rtl/hb_frame_tick.sv | 23 ++
 rtl/health_bar.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/health_bar_pkg.sv
// health_bar_pkg: shared types and sprite ROM layout for the HUD health bar.
package health_bar_pkg;

  // Trail/refill sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    FILL  = 2'd3
  } hb_state_t;

  // Sprite ROM holds four segment tiles stored back to back.
  localparam logic [1:0] TILE_FULL  = 2'd0;
  localparam logic [1:0] TILE_TRAIL = 2'd1;
  localparam logic [1:0] TILE_EMPTY = 2'd2;
  localparam logic [1:0] TILE_LOW   = 2'd3;
  localparam int         TILE_COUNT = 4;

  // Width used for every hit-point value and compare.
  localparam int HP_W = 10;

  // Pixels in one segment tile, i.e. the stride between tile bases.
  function automatic int tile_pixels(input int seg_w, input int seg_h);
    return seg_w * seg_h;
  endfunction

endpackage

// File: rtl/health_bar_if.sv
// health_bar_if: pixel query bus between the video scan logic and the bar.
// master = scan side (drives coordinates), slave = health_bar (answers).
interface health_bar_if #(
  parameter int ADDR_W = 10
);
  logic [8:0]        PixelX;
  logic [8:0]        PixelY;
  logic              is_obj;
  logic [ADDR_W-1:0] Obj_address;

  modport master (output PixelX, PixelY, input is_obj, Obj_address);
  modport slave  (input PixelX, PixelY, output is_obj, Obj_address);
endinterface

// File: rtl/hb_frame_tick.sv
// hb_frame_tick: turns the vsync-derived frame_clk level into a single
// registered one-Clk tick per rising edge, however long frame_clk stays high.
module hb_frame_tick (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);

  logic frame_q;

  // Remember last frame_clk level and register the rising-edge pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_q <= 1'b0;
      tick    <= 1'b0;
    end else begin
      frame_q <= frame_clk;
      tick    <= frame_clk & ~frame_q;
    end
  end

endmodule

// File: rtl/health_bar.sv
// health_bar: animated HUD health bar. Per frame tick it tracks displayed HP,
// a lingering damage trail and a hit-flash timer; the pixel render is
// purely combinational. Optional low-HP blink: define HEALTH_BAR_BLINK_EN.
//
//   state | meaning
//   IDLE  | trail equals displayed HP, nothing animating
//   HOLD  | trail parked above displayed HP, counting hold frames
//   DRAIN | trail shrinking by one HP per frame toward displayed HP
//   FILL  | displayed HP climbing by one per frame toward the target
module health_bar
  import health_bar_pkg::*;
#(
  parameter int SEGMENTS     = 10,
  parameter int SEG_W        = 13,
  parameter int SEG_H        = 13,
  parameter int HP_PER_SEG   = 10,
  parameter int X_POS        = 40,
  parameter int Y_POS        = 16,
  parameter int HOLD_FRAMES  = 30,
  parameter int FLASH_FRAMES = 8,
  parameter int LOW_HP       = 20,
  parameter int ADDR_W       = 10
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            frame_clk,
  input  logic [HP_W-1:0] Player_Blood,
  health_bar_if.slave     pix,
  output logic            Hit_Flash
);

  localparam int MAX_HP   = SEGMENTS * HP_PER_SEG;
  localparam int TILE_PIX = tile_pixels(SEG_W, SEG_H);
  localparam int HOLD_W   = $clog2(HOLD_FRAMES + 2);
  localparam int FLASH_W  = $clog2(FLASH_FRAMES + 2);

  logic              tick;
  logic [HP_W-1:0]   target;
  hb_state_t         state, state_nx;
  logic [HP_W-1:0]   disp_hp, disp_nx, trail_hp, trail_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic [FLASH_W-1:0] flash_cnt, flash_nx;

  hb_frame_tick u_tick (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  assign target    = (Player_Blood > HP_W'(MAX_HP)) ? HP_W'(MAX_HP) : Player_Blood;
  assign Hit_Flash = (flash_cnt != '0);

  // State and counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      disp_hp   <= HP_W'(MAX_HP);
      trail_hp  <= HP_W'(MAX_HP);
      hold_cnt  <= '0;
      flash_cnt <= '0;
    end else begin
      state     <= state_nx;
      disp_hp   <= disp_nx;
      trail_hp  <= trail_nx;
      hold_cnt  <= hold_nx;
      flash_cnt <= flash_nx;
    end
  end

  // Next-state: damage and heal override the state-specific behaviour.
  always_comb begin
    state_nx = state;
    disp_nx  = disp_hp;
    trail_nx = trail_hp;
    hold_nx  = hold_cnt;
    flash_nx = flash_cnt;
    if (tick) begin
      if (flash_cnt != '0) flash_nx = flash_cnt - 1'b1;
      if (target < disp_hp) begin
        disp_nx  = target;
        hold_nx  = HOLD_W'(HOLD_FRAMES);
        flash_nx = FLASH_W'(FLASH_FRAMES);
        state_nx = HOLD;
      end else if (target > disp_hp) begin
        disp_nx  = disp_hp + 1'b1;
        trail_nx = disp_hp + 1'b1;
        state_nx = FILL;
      end else begin
        case (state)
          HOLD: begin
            // The tick that counts the last hold frame also starts draining.
            if (hold_cnt <= HOLD_W'(1)) begin
              hold_nx  = '0;
              state_nx = DRAIN;
            end else begin
              hold_nx = hold_cnt - 1'b1;
            end
          end
          DRAIN: begin
            if (trail_hp > disp_hp + 1'b1) begin
              trail_nx = trail_hp - 1'b1;
            end else begin
              trail_nx = disp_hp;
              state_nx = IDLE;
            end
          end
          FILL:    state_nx = IDLE;
          default: ;
        endcase
      end
    end
  end

`ifdef HEALTH_BAR_BLINK_EN
  logic [3:0] blink_cnt;

  // Free-running frame counter; bit 3 is the blink phase.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)  blink_cnt <= '0;
    else if (tick) blink_cnt <= blink_cnt + 4'd1;
  end
`else
  logic low_hp_unused;
  assign low_hp_unused = (disp_hp <= HP_W'(LOW_HP));
`endif

  logic signed [10:0] dx, dy;
  logic [10:0] dx_u, dy_u, seg_k, lx;
  logic [15:0] seg_thr;
  logic [1:0]  tile;
  logic        in_bar;

  // Signed offsets so pixels left of / above the bar never wrap into it.
  assign dx = $signed({2'b00, pix.PixelX}) - $signed(11'(X_POS));
  assign dy = $signed({2'b00, pix.PixelY}) - $signed(11'(Y_POS));

  // Pixel render: pick the tile for this segment and form the ROM address.
  always_comb begin
    dx_u    = dx;
    dy_u    = dy;
    in_bar  = !dx[10] && !dy[10] && (dx_u < 11'(SEGMENTS * SEG_W)) && (dy_u < 11'(SEG_H));
    seg_k   = dx_u / 11'(SEG_W);
    lx      = dx_u % 11'(SEG_W);
    seg_thr = 16'(seg_k + 11'd1) * 16'(HP_PER_SEG);
    if (16'(disp_hp) >= seg_thr)       tile = TILE_FULL;
    else if (16'(trail_hp) >= seg_thr) tile = TILE_TRAIL;
    else                               tile = TILE_EMPTY;
`ifdef HEALTH_BAR_BLINK_EN
    if (tile == TILE_FULL && disp_hp <= HP_W'(LOW_HP) && blink_cnt[3]) tile = TILE_LOW;
`endif
  end

  assign pix.is_obj      = in_bar;
  assign pix.Obj_address = in_bar ? (ADDR_W'(tile) * ADDR_W'(TILE_PIX) + ADDR_W'(dy_u) * ADDR_W'(SEG_W) + ADDR_W'(lx))
                                  : '0;

endmodule
